muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit that produces the 2×WIDTH HI/LO result for MULT/MULTU/DIV/DIVU in the execute stage.
- Supersedes the fixed 32-bit divider behind div_stallE.
- Adds configurable width and multiplier latency, a start/done handshake, flush cancellation and a divide-by-zero flag.
- The hazard unit stalls on busy_o; the datapath captures hi_o/lo_o on done_o into the HI/LO path.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/muldiv_unit_div_radix2.sv | 75 +++++++
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit.
// Op codes are driven by the main decoder; state codes are also seen by the hazard unit.
package muldiv_pkg;

    // The DIV op code and the divide state are both 2'b10, so MD_DIV serves as both.
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_MUL  = 2'b01,
        MD_DIV  = 2'b10,
        MD_DONE = 2'b11
    } mdState_t;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // True for DIV/DIVU.
    function automatic logic isDivOp(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the two's-complement variants MULT/DIV.
    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// Iterative unsigned radix-2 restoring divider core.
// Ports: clk, rst (async active-low), start (loads operands and performs the
// first iteration), cancel (abandons the division), dividend/divisor (sampled
// with start), quotient/remainder (registered), valid (one-cycle pulse WIDTH
// cycles after start, quotient/remainder final in that cycle).
module div_radix2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] divisorReg;
    logic [WIDTH-1:0] srcRem;
    logic [WIDTH-1:0] srcQuo;
    logic [WIDTH-1:0] srcDiv;
    logic [WIDTH-1:0] nextRem;
    logic [WIDTH-1:0] nextQuo;
    logic [WIDTH:0]   diff;
    logic [CNT_W-1:0] stepCnt;
    logic             running;

    // One restoring step; the start cycle feeds fresh operands so iteration 1 overlaps the load.
    // The quotient register doubles as the shifting dividend.
    always_comb begin
        srcRem  = start ? '0 : remainder;
        srcQuo  = start ? dividend : quotient;
        srcDiv  = start ? divisor : divisorReg;
        diff    = {srcRem, srcQuo[WIDTH-1]} - {1'b0, srcDiv};
        // diff[WIDTH] is the borrow: set when the trial remainder is below the divisor.
        nextRem = diff[WIDTH] ? {srcRem[WIDTH-2:0], srcQuo[WIDTH-1]} : diff[WIDTH-1:0];
        nextQuo = {srcQuo[WIDTH-2:0], ~diff[WIDTH]};
    end

    // Iteration state and step counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient   <= '0;
            remainder  <= '0;
            divisorReg <= '0;
            stepCnt    <= '0;
            running    <= 1'b0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (cancel) begin
                running <= 1'b0;
            end else if (start) begin
                quotient   <= nextQuo;
                remainder  <= nextRem;
                divisorReg <= divisor;
                stepCnt    <= CNT_W'(1);
                running    <= 1'b1;
            end else if (running) begin
                quotient  <= nextQuo;
                remainder <= nextRem;
                stepCnt   <= stepCnt + 1'b1;
                if (stepCnt == CNT_W'(WIDTH - 1)) begin
                    running <= 1'b0;
                    valid   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit producing the HI/LO pair in execute.
// Ports: clk, rst (async active-low), start_i/op_i/a_i/b_i (request, sampled
// in IDLE when cancel_i is low), cancel_i (flush), busy_o (operation in flight),
// done_o (one-cycle result strobe), hi_o/lo_o (product halves or
// remainder/quotient, held between strobes), div_by_zero_o (valid with done_o).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int unsigned PIPE_DEPTH = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
    localparam int unsigned LAT_W      = $clog2(MUL_LAT + 1);

    mdState_t         state;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opSigned;
    logic [LAT_W-1:0] latCnt;
    logic             divSetup;

    logic [2*WIDTH-1:0] extA;
    logic [2*WIDTH-1:0] extB;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] mulResult;
    logic [2*WIDTH-1:0] mulStage [PIPE_DEPTH];

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] divLo;
    logic [WIDTH-1:0] divHi;
    logic             divNegQ;
    logic             divNegR;
    logic             divByZero;
    logic             divStart;
    logic             divValid;

    // Multiplier: extend to 2*WIDTH so the truncated product is exact for both signednesses.
    always_comb begin
        extA    = {{WIDTH{opSigned & opA[WIDTH-1]}}, opA};
        extB    = {{WIDTH{opSigned & opB[WIDTH-1]}}, opB};
        product = extA * extB;
    end

    // Retiming stages behind the multiplier; operands are held for the whole operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(PIPE_DEPTH); k++) begin
                mulStage[k] <= '0;
            end
        end else begin
            mulStage[0] <= product;
            for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                mulStage[k] <= mulStage[k-1];
            end
        end
    end

    assign mulResult = (MUL_LAT > 1) ? mulStage[PIPE_DEPTH-1] : product;

    // Divider sign handling: magnitudes in, signs restored on the way out.
    always_comb begin
        divNegQ   = opSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
        divNegR   = opSigned & opA[WIDTH-1];
        absA      = (opSigned && opA[WIDTH-1]) ? WIDTH'(-opA) : opA;
        absB      = (opSigned && opB[WIDTH-1]) ? WIDTH'(-opB) : opB;
        divByZero = (opB == '0);
        divStart  = (state == MD_DIV) && divSetup && !divByZero && !cancel_i;
        divLo     = divNegQ ? WIDTH'(-quotient) : quotient;
        divHi     = divNegR ? WIDTH'(-remainder) : remainder;
    end

    div_radix2 #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (divStart),
        .cancel   (cancel_i),
        .dividend (absA),
        .divisor  (absB),
        .quotient (quotient),
        .remainder(remainder),
        .valid    (divValid)
    );

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= MD_IDLE;
            opA           <= '0;
            opB           <= '0;
            opSigned      <= 1'b0;
            latCnt        <= '0;
            divSetup      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start_i && !cancel_i) begin
                        opA      <= a_i;
                        opB      <= b_i;
                        opSigned <= isSignedOp(op_i);
                        latCnt   <= '0;
                        busy_o   <= 1'b1;
                        if (isDivOp(op_i)) begin
                            state    <= MD_DIV;
                            divSetup <= 1'b1;
                        end else begin
                            state <= MD_MUL;
                        end
                    end
                end
                MD_MUL: begin
                    if (cancel_i) begin
                        state  <= MD_IDLE;
                        busy_o <= 1'b0;
                    end else if (latCnt == LAT_W'(MUL_LAT - 1)) begin
                        state        <= MD_DONE;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                        {hi_o, lo_o} <= mulResult;
                    end else begin
                        latCnt <= latCnt + 1'b1;
                    end
                end
                MD_DIV: begin
                    if (cancel_i) begin
                        state    <= MD_IDLE;
                        busy_o   <= 1'b0;
                        divSetup <= 1'b0;
                    end else if (divSetup) begin
                        divSetup <= 1'b0;
                        // A zero divisor skips the iterations and finishes right after setup.
                        if (divByZero) begin
                            state         <= MD_DONE;
                            busy_o        <= 1'b0;
                            done_o        <= 1'b1;
                            div_by_zero_o <= 1'b1;
                            lo_o          <= '1;
                            hi_o          <= opA;
                        end
                    end else if (divValid) begin
                        state  <= MD_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        lo_o   <= divLo;
                        hi_o   <= divHi;
                    end
                end
                MD_DONE: begin
                    // Results are committed already; a flush here changes nothing.
                    state <= MD_IDLE;
                end
                default: begin
                    state  <= MD_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: three builds (32/lat1, 32/lat3, 16/lat1).
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst;
    logic        cancel;
    logic [1:0]  op;
    logic [31:0] aIn, bIn;
    logic [15:0] a16, b16;
    logic        s32, sL3, s16;

    logic        busy32, done32, dbz32;
    logic [31:0] hi32, lo32;
    logic        busyL3, doneL3, dbzL3;
    logic [31:0] hiL3, loL3;
    logic        busy16, done16, dbz16;
    logic [15:0] hi16, lo16;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(1)) dut32 (
        .clk(clk), .rst(rst), .start_i(s32), .op_i(op), .a_i(aIn), .b_i(bIn),
        .cancel_i(cancel), .busy_o(busy32), .done_o(done32), .hi_o(hi32),
        .lo_o(lo32), .div_by_zero_o(dbz32));

    muldiv_unit #(.WIDTH(32), .MUL_LAT(3)) dutL3 (
        .clk(clk), .rst(rst), .start_i(sL3), .op_i(op), .a_i(aIn), .b_i(bIn),
        .cancel_i(cancel), .busy_o(busyL3), .done_o(doneL3), .hi_o(hiL3),
        .lo_o(loL3), .div_by_zero_o(dbzL3));

    muldiv_unit #(.WIDTH(16), .MUL_LAT(1)) dut16 (
        .clk(clk), .rst(rst), .start_i(s16), .op_i(op), .a_i(a16), .b_i(b16),
        .cancel_i(cancel), .busy_o(busy16), .done_o(done16), .hi_o(hi16),
        .lo_o(lo16), .div_by_zero_o(dbz16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic doneOf(input int which);
        case (which)
            0: return done32;
            1: return doneL3;
            default: return done16;
        endcase
    endfunction

    function automatic logic busyOf(input int which);
        case (which)
            0: return busy32;
            1: return busyL3;
            default: return busy16;
        endcase
    endfunction

    function automatic logic dbzOf(input int which);
        case (which)
            0: return dbz32;
            1: return dbzL3;
            default: return dbz16;
        endcase
    endfunction

    function automatic logic [31:0] hiOf(input int which);
        case (which)
            0: return hi32;
            1: return hiL3;
            default: return {16'h0, hi16};
        endcase
    endfunction

    function automatic logic [31:0] loOf(input int which);
        case (which)
            0: return lo32;
            1: return loL3;
            default: return {16'h0, lo16};
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge of cycle 0 (after the accept edge).
    task automatic startOp(input int which, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op  = o;
        aIn = x;
        bIn = y;
        a16 = x[15:0];
        b16 = y[15:0];
        case (which)
            0: s32 = 1'b1;
            1: sL3 = 1'b1;
            default: s16 = 1'b1;
        endcase
        @(negedge clk);
        s32 = 1'b0;
        sL3 = 1'b0;
        s16 = 1'b0;
    endtask

    // Samples from cycle startCyc until done or limit; dc = -1 when no done was seen.
    task automatic waitDone(input int which, input int startCyc, input int limit, output int dc, output int bc);
        dc = -1;
        bc = 0;
        for (int c = startCyc; c <= limit; c++) begin
            if (c != startCyc) @(negedge clk);
            if (doneOf(which)) begin
                dc = c;
                break;
            end
            if (busyOf(which)) bc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            checks++; if (busyOf(w) !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", w, busyOf(w)); end
            checks++; if (doneOf(w) !== 1'b0) begin failures++; $display("FAIL reset_done[%0d] got=%b exp=0", w, doneOf(w)); end
            checks++; if (dbzOf(w) !== 1'b0) begin failures++; $display("FAIL reset_dbz[%0d] got=%b exp=0", w, dbzOf(w)); end
            checks++; if (hiOf(w) !== 32'h0) begin failures++; $display("FAIL reset_hi[%0d] got=%h exp=0", w, hiOf(w)); end
            checks++; if (loOf(w) !== 32'h0) begin failures++; $display("FAIL reset_lo[%0d] got=%h exp=0", w, loOf(w)); end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [1:0]  vo [4];
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [63:0] vp [4];
        int dc, bc;
        vo = '{OP_MULT, OP_MULT, OP_MULTU, OP_MULT};
        va = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        vb = '{32'd5, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF};
        vp = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h4000_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h1};
        for (int i = 0; i < 4; i++) begin
            startOp(0, vo[i], va[i], vb[i]);
            waitDone(0, 0, 10, dc, bc);
            checks++; if (dc !== 1) begin failures++; $display("FAIL mult_lat[%0d] got=%0d exp=1", i, dc); end
            checks++; if (bc !== 1) begin failures++; $display("FAIL mult_busy_cycles[%0d] got=%0d exp=1", i, bc); end
            checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL mult_busy_at_done[%0d] got=%b exp=0", i, busy32); end
            checks++; if ({hi32, lo32} !== vp[i]) begin failures++; $display("FAIL mult_result[%0d] got=%h exp=%h", i, {hi32, lo32}, vp[i]); end
            @(negedge clk);
            checks++; if (done32 !== 1'b0) begin failures++; $display("FAIL mult_done_pulse[%0d] got=%b exp=0", i, done32); end
        end
    endtask

    task automatic test_mul_lat3();
        logic [1:0]  vo [2];
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [63:0] vp [2];
        int dc, bc;
        vo = '{OP_MULTU, OP_MULT};
        va = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vb = '{32'hFFFF_FFFF, 32'd5};
        vp = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1};
        for (int i = 0; i < 2; i++) begin
            startOp(1, vo[i], va[i], vb[i]);
            waitDone(1, 0, 10, dc, bc);
            checks++; if (dc !== 3) begin failures++; $display("FAIL lat3_latency[%0d] got=%0d exp=3", i, dc); end
            checks++; if (bc !== 3) begin failures++; $display("FAIL lat3_busy_cycles[%0d] got=%0d exp=3", i, bc); end
            checks++; if ({hiL3, loL3} !== vp[i]) begin failures++; $display("FAIL lat3_result[%0d] got=%h exp=%h", i, {hiL3, loL3}, vp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_div();
        logic [1:0]  vo [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vq [3];
        logic [31:0] vr [3];
        int dc, bc;
        vo = '{OP_DIVU, OP_DIV, OP_DIV};
        va = '{32'd100, 32'd7, 32'h8000_0000};
        vb = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        vq = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000};
        vr = '{32'd2, 32'd1, 32'd0};
        for (int i = 0; i < 3; i++) begin
            startOp(0, vo[i], va[i], vb[i]);
            waitDone(0, 0, 60, dc, bc);
            checks++; if (dc !== 33) begin failures++; $display("FAIL div_lat[%0d] got=%0d exp=33", i, dc); end
            checks++; if (bc !== 33) begin failures++; $display("FAIL div_busy_cycles[%0d] got=%0d exp=33", i, bc); end
            checks++; if (dbz32 !== 1'b0) begin failures++; $display("FAIL div_dbz[%0d] got=%b exp=0", i, dbz32); end
            checks++; if (lo32 !== vq[i]) begin failures++; $display("FAIL div_quot[%0d] got=%h exp=%h", i, lo32, vq[i]); end
            checks++; if (hi32 !== vr[i]) begin failures++; $display("FAIL div_rem[%0d] got=%h exp=%h", i, hi32, vr[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_start_while_busy();
        int dc, bc;
        startOp(0, OP_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int c = 0; c < 5; c++) @(negedge clk);
        op  = OP_MULT;
        aIn = 32'd2;
        bIn = 32'd2;
        s32 = 1'b1;
        @(negedge clk);
        s32 = 1'b0;
        waitDone(0, 6, 60, dc, bc);
        checks++; if (dc !== 33) begin failures++; $display("FAIL busy_start_lat got=%0d exp=33", dc); end
        checks++; if (lo32 !== 32'hFFFF_FFFD) begin failures++; $display("FAIL busy_start_quot got=%h exp=fffffffd", lo32); end
        checks++; if (hi32 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL busy_start_rem got=%h exp=ffffffff", hi32); end
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        int dc, bc;
        startOp(0, OP_DIV, 32'h1234_5678, 32'd0);
        waitDone(0, 0, 10, dc, bc);
        checks++; if (dc !== 1) begin failures++; $display("FAIL dbz_lat got=%0d exp=1", dc); end
        checks++; if (dbz32 !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", dbz32); end
        checks++; if (lo32 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dbz_lo got=%h exp=ffffffff", lo32); end
        checks++; if (hi32 !== 32'h1234_5678) begin failures++; $display("FAIL dbz_hi got=%h exp=12345678", hi32); end
        @(negedge clk);
        checks++; if (dbz32 !== 1'b0) begin failures++; $display("FAIL dbz_after_done got=%b exp=0", dbz32); end
        startOp(0, OP_MULTU, 32'd3, 32'd4);
        waitDone(0, 0, 10, dc, bc);
        checks++; if (dc !== 1) begin failures++; $display("FAIL dbz_next_lat got=%0d exp=1", dc); end
        checks++; if (dbz32 !== 1'b0) begin failures++; $display("FAIL dbz_next_flag got=%b exp=0", dbz32); end
        checks++; if (lo32 !== 32'd12) begin failures++; $display("FAIL dbz_next_lo got=%h exp=c", lo32); end
        @(negedge clk);
    endtask

    task automatic test_cancel();
        int dc, bc, seen;
        startOp(0, OP_DIVU, 32'd1000, 32'd3);
        for (int c = 0; c < 10; c++) @(negedge clk);
        cancel = 1'b1;
        checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL cancel_busy_before got=%b exp=1", busy32); end
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL cancel_busy_after got=%b exp=0", busy32); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (done32) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL cancel_no_done got=%0d exp=0", seen); end
        checks++; if ({hi32, lo32} !== 64'd12) begin failures++; $display("FAIL cancel_hold got=%h exp=c", {hi32, lo32}); end
        startOp(0, OP_DIVU, 32'd9, 32'd3);
        waitDone(0, 0, 60, dc, bc);
        checks++; if (dc !== 33) begin failures++; $display("FAIL cancel_next_lat got=%0d exp=33", dc); end
        checks++; if (lo32 !== 32'd3) begin failures++; $display("FAIL cancel_next_quot got=%h exp=3", lo32); end
        checks++; if (hi32 !== 32'd0) begin failures++; $display("FAIL cancel_next_rem got=%h exp=0", hi32); end
        @(negedge clk);
    endtask

    task automatic test_cancel_start();
        int seen;
        op     = OP_MULTU;
        aIn    = 32'd5;
        bIn    = 32'd5;
        s32    = 1'b1;
        cancel = 1'b1;
        @(negedge clk);
        s32    = 1'b0;
        cancel = 1'b0;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL cancel_start_busy got=%b exp=0", busy32); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (done32) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL cancel_start_no_done got=%0d exp=0", seen); end
        checks++; if (lo32 !== 32'd3) begin failures++; $display("FAIL cancel_start_hold got=%h exp=3", lo32); end
    endtask

    task automatic test_back_to_back();
        int dc, bc;
        startOp(0, OP_MULT, 32'hFFFF_FFFD, 32'd5);
        waitDone(0, 0, 10, dc, bc);
        checks++; if (dc !== 1) begin failures++; $display("FAIL b2b_first_lat got=%0d exp=1", dc); end
        op  = OP_MULTU;
        aIn = 32'd6;
        bIn = 32'd7;
        s32 = 1'b1;
        @(negedge clk);
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", busy32); end
        @(negedge clk);
        s32 = 1'b0;
        checks++; if (busy32 !== 1'b1) begin failures++; $display("FAIL b2b_accept_busy got=%b exp=1", busy32); end
        @(negedge clk);
        checks++; if (done32 !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done32); end
        checks++; if ({hi32, lo32} !== 64'd42) begin failures++; $display("FAIL b2b_result got=%h exp=2a", {hi32, lo32}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dc, bc, seen;
        startOp(0, OP_MULT, 32'hFFFF_FFFD, 32'd5);
        waitDone(0, 0, 10, dc, bc);
        @(negedge clk);
        startOp(0, OP_DIVU, 32'd1000, 32'd3);
        for (int c = 0; c < 5; c++) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy32 !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy32); end
        checks++; if (hi32 !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", hi32); end
        checks++; if (lo32 !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", lo32); end
        checks++; if (hiL3 !== 32'h0) begin failures++; $display("FAIL rstmid_hi_lat3 got=%h exp=0", hiL3); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_width16();
        logic [1:0]  vo [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [31:0] vq [3];
        logic [31:0] vr [3];
        int          vl [3];
        logic        vz [3];
        int dc, bc;
        vo = '{OP_DIV, OP_DIVU, OP_DIVU};
        va = '{32'h8000, 32'hFFFF, 32'h00AB};
        vb = '{32'hFFFF, 32'h00FF, 32'h0000};
        vq = '{32'h8000, 32'h0101, 32'hFFFF};
        vr = '{32'h0000, 32'h0000, 32'h00AB};
        vl = '{17, 17, 1};
        vz = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            startOp(2, vo[i], va[i], vb[i]);
            waitDone(2, 0, 40, dc, bc);
            checks++; if (dc !== vl[i]) begin failures++; $display("FAIL w16_lat[%0d] got=%0d exp=%0d", i, dc, vl[i]); end
            checks++; if (dbz16 !== vz[i]) begin failures++; $display("FAIL w16_dbz[%0d] got=%b exp=%b", i, dbz16, vz[i]); end
            checks++; if (loOf(2) !== vq[i]) begin failures++; $display("FAIL w16_quot[%0d] got=%h exp=%h", i, loOf(2), vq[i]); end
            checks++; if (hiOf(2) !== vr[i]) begin failures++; $display("FAIL w16_rem[%0d] got=%h exp=%h", i, hiOf(2), vr[i]); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst    = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        aIn    = '0;
        bIn    = '0;
        a16    = '0;
        b16    = '0;
        s32    = 1'b0;
        sL3    = 1'b0;
        s16    = 1'b0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_mul_lat3();
        test_div();
        test_start_while_busy();
        test_div_zero();
        test_cancel();
        test_cancel_start();
        test_back_to_back();
        test_reset_mid();
        test_width16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
